// File: rtl/nem_ohmux_sel_ctrl.sv
// Select controller for a 2-input, 8-bit one-hot NEM relay mux.
// Arbitrates two requesters round-robin, waits for relay pull-in before
// granting, and enforces a release interval (break-before-make) before
// any other path may be selected.
module nem_ohmux_sel_ctrl #(
    parameter int unsigned PULL_IN_CYC = 4,
    parameter int unsigned RELEASE_CYC = 3
) (
    input  logic CP,
    input  logic CDN,
    input  logic REQ0,
    input  logic REQ1,
    output logic GNT0,
    output logic GNT1,
    output logic S0,
    output logic S1,
    output logic BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAKE  = 2'd1,
        GRANT = 2'd2,
        BREAK = 2'd3
    } state_t;

    localparam logic [7:0] PULL_LOAD = 8'(PULL_IN_CYC);
    localparam logic [7:0] REL_LOAD  = 8'(RELEASE_CYC);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       own;
    logic       own_nxt;
    logic       last;
    logic       last_nxt;
    logic       req_own;
    logic       path_on;
    logic       s0_nxt;
    logic       s1_nxt;
    logic       gnt0_nxt;
    logic       gnt1_nxt;
    logic       busy_nxt;

    // Next-state logic; the owner's request is the only one that matters once a path is chosen.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        own_nxt   = own;
        last_nxt  = last;
        req_own   = own ? REQ1 : REQ0;
        case (state)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    state_nxt = MAKE;
                    cnt_nxt   = PULL_LOAD;
                    own_nxt   = (REQ0 && REQ1) ? ~last : REQ1;
                end
            end
            MAKE: begin
                if (!req_own) begin
                    state_nxt = BREAK;
                    cnt_nxt   = REL_LOAD;
                end else if (cnt == 8'd1) begin
                    state_nxt = GRANT;
                    cnt_nxt   = 8'd0;
                    last_nxt  = own;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            GRANT: begin
                if (!req_own) begin
                    state_nxt = BREAK;
                    cnt_nxt   = REL_LOAD;
                end
            end
            BREAK: begin
                if (cnt == 8'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        path_on  = (state_nxt == MAKE) || (state_nxt == GRANT);
        s0_nxt   = path_on && !own_nxt;
        s1_nxt   = path_on && own_nxt;
        gnt0_nxt = (state_nxt == GRANT) && !own_nxt;
        gnt1_nxt = (state_nxt == GRANT) && own_nxt;
        busy_nxt = (state_nxt != IDLE);
    end

    // State, counter, arbitration and output registers; reset drops the selects at once.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state <= IDLE;
            cnt   <= 8'd0;
            own   <= 1'b0;
            last  <= 1'b1;
            S0    <= 1'b0;
            S1    <= 1'b0;
            GNT0  <= 1'b0;
            GNT1  <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            own   <= own_nxt;
            last  <= last_nxt;
            S0    <= s0_nxt;
            S1    <= s1_nxt;
            GNT0  <= gnt0_nxt;
            GNT1  <= gnt1_nxt;
            BUSY  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// Directed scoreboard bench for nem_ohmux_sel_ctrl with default timing (pull-in 4, release 3).
module tb_nem_ohmux_sel_ctrl;

    logic CP = 1'b0;
    logic CDN;
    logic REQ0;
    logic REQ1;
    logic GNT0;
    logic GNT1;
    logic S0;
    logic S1;
    logic BUSY;

    int tests_run    = 0;
    int tests_failed = 0;

    // Output vector order: {S0, S1, GNT0, GNT1, BUSY}
    localparam logic [4:0] OUT_IDLE = 5'b00000;
    localparam logic [4:0] OUT_MK0  = 5'b10001;
    localparam logic [4:0] OUT_GR0  = 5'b10101;
    localparam logic [4:0] OUT_MK1  = 5'b01001;
    localparam logic [4:0] OUT_GR1  = 5'b01011;
    localparam logic [4:0] OUT_BRK  = 5'b00001;

    logic [4:0] exp_q[$];
    string      tag_q[$];

    nem_ohmux_sel_ctrl #(
        .PULL_IN_CYC(4),
        .RELEASE_CYC(3)
    ) dut (
        .CP  (CP),
        .CDN (CDN),
        .REQ0(REQ0),
        .REQ1(REQ1),
        .GNT0(GNT0),
        .GNT1(GNT1),
        .S0  (S0),
        .S1  (S1),
        .BUSY(BUSY)
    );

    // Free-running clock.
    always #5 CP = ~CP;

    // Break-before-make invariant checked every cycle away from the active edge.
    always @(negedge CP) begin
        if (CDN === 1'b1) begin
            tests_run++;
            assert (!(S0 === 1'b1 && S1 === 1'b1)) else begin
                tests_failed++;
                $error("[TB] FAIL both_selects observed S0=%b S1=%b expected not both 1", S0, S1);
            end
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    // Pop the oldest expectation and compare against the live outputs.
    task automatic check_output();
        logic [4:0] exp;
        logic [4:0] obs;
        string      tag;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_empty observed empty queue expected an entry");
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            obs = {S0, S1, GNT0, GNT1, BUSY};
            assert (obs === exp) else begin
                tests_failed++;
                $error("[TB] FAIL %s observed {S0,S1,GNT0,GNT1,BUSY}=%b expected %b", tag, obs, exp);
            end
        end
    endtask

    // Drive requests for one edge, queue the expected outputs, check after the edge.
    task automatic apply_stimulus(input logic r0, input logic r1, input logic [4:0] exp, input string tag);
        @(negedge CP);
        REQ0 = r0;
        REQ1 = r1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge CP);
        #1;
        check_output();
    endtask

    // Immediate check without waiting for a clock edge (reset behaviour).
    task automatic check_now(input logic [4:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        check_output();
    endtask

    // Directed sequence.
    initial begin
        CDN  = 1'b0;
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        #12;
        check_now(OUT_IDLE, "reset_state");
        @(negedge CP);
        CDN = 1'b1;

        // Single requester 0: S0 from edge 0, GNT0 from edge 4.
        apply_stimulus(1'b1, 1'b0, OUT_MK0, "mk0_edge0");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, OUT_MK0, "mk0_settle");
        apply_stimulus(1'b1, 1'b0, OUT_GR0, "gnt0_edge4");
        apply_stimulus(1'b1, 1'b0, OUT_GR0, "gnt0_hold");

        // Requester 1 cannot preempt.
        apply_stimulus(1'b1, 1'b1, OUT_GR0, "gnt0_req1_raised");
        apply_stimulus(1'b1, 1'b1, OUT_GR0, "gnt0_no_preempt");

        // Release: BUSY through n+2, IDLE at n+3, then MAKE for requester 1.
        apply_stimulus(1'b0, 1'b1, OUT_BRK, "brk_n");
        apply_stimulus(1'b0, 1'b1, OUT_BRK, "brk_n1");
        apply_stimulus(1'b0, 1'b1, OUT_BRK, "brk_n2");
        apply_stimulus(1'b0, 1'b1, OUT_IDLE, "idle_n3");
        apply_stimulus(1'b0, 1'b1, OUT_MK1, "mk1_n4");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, OUT_MK1, "mk1_settle");
        apply_stimulus(1'b0, 1'b1, OUT_GR1, "gnt1");

        // Asynchronous reset during GRANT1, released before the next edge.
        #1;
        CDN = 1'b0;
        #1;
        check_now(OUT_IDLE, "async_reset_gnt1");
        #1;
        CDN = 1'b1;
        apply_stimulus(1'b0, 1'b1, OUT_MK1, "remake_after_reset");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, OUT_MK1, "remake_settle");
        apply_stimulus(1'b0, 1'b1, OUT_GR1, "regrant1");

        // Release requester 1 and return to IDLE.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, OUT_BRK, "brk_gnt1");
        apply_stimulus(1'b0, 1'b0, OUT_IDLE, "idle_after_gnt1");

        // Abort during MAKE: no grant pulse, full release interval.
        apply_stimulus(1'b1, 1'b0, OUT_MK0, "abort_mk0_e0");
        apply_stimulus(1'b1, 1'b0, OUT_MK0, "abort_mk0_e1");
        apply_stimulus(1'b0, 1'b0, OUT_BRK, "abort_brk");
        apply_stimulus(1'b0, 1'b0, OUT_BRK, "abort_brk1");
        apply_stimulus(1'b0, 1'b0, OUT_BRK, "abort_brk2");
        apply_stimulus(1'b0, 1'b0, OUT_IDLE, "abort_idle");

        // Both requesting: round-robin alternates owners across releases.
        apply_stimulus(1'b1, 1'b1, OUT_MK0, "both_first_own0");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, OUT_MK0, "both_mk0");
        apply_stimulus(1'b1, 1'b1, OUT_GR0, "both_gnt0");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, OUT_BRK, "both_brk0");
        apply_stimulus(1'b1, 1'b1, OUT_IDLE, "both_idle0");
        apply_stimulus(1'b1, 1'b1, OUT_MK1, "both_second_own1");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, OUT_MK1, "both_mk1");
        apply_stimulus(1'b1, 1'b1, OUT_GR1, "both_gnt1");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, OUT_BRK, "both_brk1");
        apply_stimulus(1'b1, 1'b1, OUT_IDLE, "both_idle1");
        apply_stimulus(1'b1, 1'b1, OUT_MK0, "both_third_own0");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
